// File: rtl/wb_arbiter_pkg.sv
// Shared core constants and the writeback source encoding used by the arbiter.
package wb_arbiter_pkg;

  localparam int unsigned CoreW       = 32;
  localparam int unsigned CoreR       = 5;
  localparam int unsigned CoreNumRegs = 32;
  localparam int unsigned X0          = 0;

  typedef enum logic [1:0] {
    SrcNone,
    SrcAlu,
    SrcFifo,
    SrcBypass
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding MUL/DIV results awaiting a free writeback slot.
module wb_fifo #(
  parameter int unsigned Width = 37,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + CntW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and buffered MUL/DIV results into one registered
// regfile write port and tracks in-flight MUL/DIV destinations for hazard stalls.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned W          = CoreW,
  parameter int unsigned R          = CoreR,
  parameter int unsigned NUM_REGS   = CoreNumRegs,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic         clk,
  input  logic         a_reset_n,
  input  logic         alu_valid,
  input  logic [R-1:0] alu_rd,
  input  logic [W-1:0] alu_result,
  output logic         alu_stall,
  input  logic         mdu_valid,
  output logic         mdu_ready,
  input  logic [R-1:0] mdu_rd,
  input  logic [W-1:0] mdu_result,
  input  logic         md_issue,
  input  logic [R-1:0] md_issue_rd,
  input  logic [R-1:0] addr1,
  input  logic [R-1:0] addr2,
  input  logic [R-1:0] rd_chk,
  output logic         rs1_busy,
  output logic         rs2_busy,
  output logic         rd_busy,
  output logic [W-1:0] result,
  output logic [R-1:0] rd,
  output logic         useRd_slv
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW   = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LimCnt = SW'(STARVE_LIM);

  logic [CntW-1:0]     fifo_count;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [R+W-1:0]      fifo_rdata;
  logic [R-1:0]        head_rd;
  logic [W-1:0]        head_data;

  logic                alu_cand, md_keep;
  wb_src_e             src;
  logic [SW-1:0]       starve_q, starve_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                wr_en_q, wr_en_d;
  logic [R-1:0]        wr_rd_q, wr_rd_d;
  logic [W-1:0]        wr_data_q, wr_data_d;

  wb_fifo #(
    .Width(R + W),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (a_reset_n),
    .push_i (fifo_push),
    .wdata_i({mdu_rd, mdu_result}),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign {head_rd, head_data} = fifo_rdata;

  assign alu_stall = (fifo_count != '0) && (starve_q == LimCnt);
  assign mdu_ready = !fifo_full;
  assign rs1_busy  = pending_q[addr1];
  assign rs2_busy  = pending_q[addr2];
  assign rd_busy   = pending_q[rd_chk];

  assign useRd_slv = wr_en_q;
  assign rd        = wr_rd_q;
  assign result    = wr_data_q;

  always_comb begin
    alu_cand = alu_valid && (alu_rd != R'(X0));
    // rd==0 handshakes are accepted but never stored or written.
    md_keep  = mdu_valid && !fifo_full && (mdu_rd != R'(X0));

    src = SrcNone;
    if (alu_cand && !alu_stall) src = SrcAlu;
    else if (!fifo_empty)       src = SrcFifo;
    else if (md_keep)           src = SrcBypass;

    fifo_pop  = (src == SrcFifo);
    fifo_push = md_keep && (src != SrcBypass);

    wr_en_d   = (src != SrcNone);
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    unique case (src)
      SrcAlu: begin
        wr_rd_d   = alu_rd;
        wr_data_d = alu_result;
      end
      SrcFifo: begin
        wr_rd_d   = head_rd;
        wr_data_d = head_data;
      end
      SrcBypass: begin
        wr_rd_d   = mdu_rd;
        wr_data_d = mdu_result;
      end
      default: ;
    endcase

    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (src == SrcAlu && starve_q != LimCnt) begin
      starve_d = starve_q + SW'(1);
    end

    // Clear first so a same-cycle issue to the same register wins.
    pending_d = pending_q;
    if (src == SrcFifo)        pending_d[head_rd] = 1'b0;
    else if (src == SrcBypass) pending_d[mdu_rd]  = 1'b0;
    if (md_issue && (md_issue_rd != R'(X0))) pending_d[md_issue_rd] = 1'b1;
    pending_d[X0] = 1'b0;
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic        clk = 1'b0;
  logic        a_reset_n;
  logic        alu_valid, mdu_valid, md_issue;
  logic [4:0]  alu_rd, mdu_rd, md_issue_rd, addr1, addr2, rd_chk;
  logic [31:0] alu_result, mdu_result;
  logic        alu_stall, mdu_ready, rs1_busy, rs2_busy, rd_busy, useRd_slv;
  logic [31:0] result;
  logic [4:0]  rd;

  wb_arbiter dut (
    .clk        (clk),
    .a_reset_n  (a_reset_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_result (alu_result),
    .alu_stall  (alu_stall),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_rd     (mdu_rd),
    .mdu_result (mdu_result),
    .md_issue   (md_issue),
    .md_issue_rd(md_issue_rd),
    .addr1      (addr1),
    .addr2      (addr2),
    .rd_chk     (rd_chk),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rd_busy    (rd_busy),
    .result     (result),
    .rd         (rd),
    .useRd_slv  (useRd_slv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_fifo[$];
  bit          m_pend[32];
  int          m_starve;
  logic        m_use;
  logic [4:0]  m_rd;
  logic [31:0] m_res;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_starve = 0;
    m_use = 0;
    m_rd = '0;
    m_res = '0;
  endtask

  // One clock of the arbiter's rules, applied to the inputs currently driven.
  task automatic model_step();
    int   size0;
    bit   stall, ready, wrote, popped, alu_won, bypassed;
    ent_t e;
    if (!a_reset_n) return;
    size0 = m_fifo.size();
    stall = (size0 > 0) && (m_starve == LIM);
    ready = size0 < DEPTH;
    wrote = 0; popped = 0; alu_won = 0; bypassed = 0;
    m_use = 0;
    if (alu_valid && alu_rd != 0 && !stall) begin
      m_use = 1; m_rd = alu_rd; m_res = alu_result; alu_won = 1;
    end else if (size0 > 0) begin
      e = m_fifo.pop_front();
      m_use = 1; m_rd = e.rd; m_res = e.data; popped = 1;
      m_pend[e.rd] = 0;
    end else if (mdu_valid && ready && mdu_rd != 0) begin
      m_use = 1; m_rd = mdu_rd; m_res = mdu_result; bypassed = 1;
      m_pend[mdu_rd] = 0;
    end
    if (size0 == 0 || popped) m_starve = 0;
    else if (alu_won && m_starve < LIM) m_starve++;
    if (mdu_valid && ready && mdu_rd != 0 && !bypassed)
      m_fifo.push_back('{rd: mdu_rd, data: mdu_result});
    if (md_issue && md_issue_rd != 0) m_pend[md_issue_rd] = 1;
  endtask

  task automatic compare();
    chk("useRd_slv", useRd_slv, m_use);
    chk("rd", rd, m_rd);
    chk("result", result, m_res);
    chk("alu_stall", alu_stall, (m_fifo.size() > 0 && m_starve == LIM));
    chk("mdu_ready", mdu_ready, (m_fifo.size() < DEPTH));
    chk("rs1_busy", rs1_busy, m_pend[addr1]);
    chk("rs2_busy", rs2_busy, m_pend[addr2]);
    chk("rd_busy", rd_busy, m_pend[rd_chk]);
  endtask

  // Inputs are set just after a rising edge; outputs are compared on the falling edge.
  task automatic cycle();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_result = 0;
    md_issue = 0; md_issue_rd = 0;
    addr1 = 0; addr2 = 0; rd_chk = 0;
  endtask

  task automatic do_reset();
    a_reset_n = 0;
    model_reset();
    idle_in();
    cycle();
    cycle();
    a_reset_n = 1;
  endtask

  initial begin
    idle_in();
    do_reset();

    // ALU-only write, then rd==0 suppressed with rd/result held.
    alu_valid = 1; alu_rd = 5; alu_result = 32'hDEAD_BEEF;
    cycle();
    idle_in();
    chk("lit_alu_use", useRd_slv, 1);
    chk("lit_alu_rd", rd, 5);
    chk("lit_alu_res", result, 32'hDEAD_BEEF);
    alu_valid = 1; alu_rd = 0; alu_result = 32'h1;
    cycle();
    idle_in();
    chk("lit_rd0_use", useRd_slv, 0);
    chk("lit_rd0_hold", rd, 5);

    // MUL path with scoreboard.
    md_issue = 1; md_issue_rd = 7; addr1 = 7;
    cycle();
    md_issue = 0;
    chk("lit_busy7", rs1_busy, 1);
    mdu_valid = 1; mdu_rd = 7; mdu_result = 32'h12;
    cycle();
    mdu_valid = 0;
    chk("lit_mdu_rd", rd, 7);
    chk("lit_mdu_res", result, 32'h12);
    chk("lit_busy7_clr", rs1_busy, 0);
    idle_in();

    // Contention: ALU first, MDU next idle cycle.
    alu_valid = 1; alu_rd = 3; alu_result = 32'hA;
    mdu_valid = 1; mdu_rd = 4; mdu_result = 32'hB;
    cycle();
    idle_in();
    chk("lit_cont_alu", rd, 3);
    cycle();
    chk("lit_cont_mdu", rd, 4);
    chk("lit_cont_mdu_res", result, 32'hB);

    // Fill FIFO under constant ALU pressure, then starvation release.
    alu_valid = 1; alu_rd = 1; alu_result = 32'h100;
    mdu_valid = 1; mdu_rd = 10; mdu_result = 32'hC;
    cycle();
    mdu_rd = 11; mdu_result = 32'hD;
    cycle();
    mdu_valid = 0;
    chk("lit_full_ready", mdu_ready, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("lit_stall", alu_stall, 1);
    cycle();
    chk("lit_forced_rd", rd, 10);
    chk("lit_forced_res", result, 32'hC);
    chk("lit_stall_drop", alu_stall, 0);
    cycle();
    chk("lit_alu_after", rd, 1);
    idle_in();
    cycle();
    cycle();

    // Set/clear collision on register 9.
    md_issue = 1; md_issue_rd = 9;
    cycle();
    md_issue = 0;
    alu_valid = 1; alu_rd = 2; alu_result = 32'h22;
    mdu_valid = 1; mdu_rd = 9; mdu_result = 32'h99;
    cycle();
    idle_in();
    md_issue = 1; md_issue_rd = 9; addr2 = 9;
    cycle();
    md_issue = 0;
    chk("lit_coll_rd", rd, 9);
    chk("lit_coll_busy", rs2_busy, 1);
    cycle();
    mdu_valid = 1; mdu_rd = 9; mdu_result = 32'h98;
    cycle();
    idle_in();

    // Reset mid-run with a full FIFO and pending bits.
    alu_valid = 1; alu_rd = 1; alu_result = 32'h5;
    md_issue = 1; md_issue_rd = 20; mdu_valid = 1; mdu_rd = 21; mdu_result = 32'h21;
    cycle();
    md_issue_rd = 22; mdu_rd = 23; mdu_result = 32'h23;
    cycle();
    idle_in();
    a_reset_n = 0;
    model_reset();
    addr1 = 20; addr2 = 22; rd_chk = 12;
    #1;
    chk("lit_rst_use", useRd_slv, 0);
    chk("lit_rst_rd", rd, 0);
    chk("lit_rst_res", result, 0);
    chk("lit_rst_ready", mdu_ready, 1);
    chk("lit_rst_busy1", rs1_busy, 0);
    chk("lit_rst_busy2", rs2_busy, 0);
    chk("lit_rst_stall", alu_stall, 0);
    cycle();
    a_reset_n = 1;
    for (int i = 0; i < 3; i++) cycle();

    // Randomised traffic on a narrow register range to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      alu_valid   = ($urandom_range(0, 99) < 55);
      alu_rd      = 5'($urandom_range(0, 15));
      alu_result  = $urandom;
      mdu_valid   = ($urandom_range(0, 99) < 35);
      mdu_rd      = 5'($urandom_range(0, 15));
      mdu_result  = $urandom;
      md_issue    = ($urandom_range(0, 99) < 30);
      md_issue_rd = 5'($urandom_range(0, 15));
      addr1       = 5'($urandom_range(0, 15));
      addr2       = 5'($urandom_range(0, 15));
      rd_chk      = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cycle();
      end
    end
    idle_in();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
